// File: rtl/cpu_control_if.sv
// Control bundle between cpu_control_fsm (master) and the 16-bit datapath (slave).
// retiredCount is present only when CPU_CONTROL_RETIRE_COUNT_EN is defined.
interface cpu_control_if;
  logic [15:0] instruction;
  logic        blockRamReadEnable;
  logic        blockRamWriteEnable;
  logic        registerFileWriteEnable;
  logic [1:0]  integerTypeSelectionLine;
  logic        reg2OrImmediateSelectionLine;
  logic        pcOrRegisterSelectionLine;
  logic        addressFromRegOrDecoderSelectionLine;
  logic        writeBackToRegRamOrALUSelectionLine;
  logic        pcOrAluOutputRamReadSelectionLine;
  logic [15:0] decoderRamWriteAddress;
  logic [3:0]  registerWriteAddress;
  logic        instructionRegisterLoad;
  logic        pcIncrement;
  logic        halted;
`ifdef CPU_CONTROL_RETIRE_COUNT_EN
  logic [31:0] retiredCount;
`endif

  modport master (
    input  instruction,
    output blockRamReadEnable, blockRamWriteEnable, registerFileWriteEnable,
    output integerTypeSelectionLine, reg2OrImmediateSelectionLine,
    output pcOrRegisterSelectionLine, addressFromRegOrDecoderSelectionLine,
    output writeBackToRegRamOrALUSelectionLine, pcOrAluOutputRamReadSelectionLine,
    output decoderRamWriteAddress, registerWriteAddress,
    output instructionRegisterLoad, pcIncrement, halted
`ifdef CPU_CONTROL_RETIRE_COUNT_EN
    , output retiredCount
`endif
  );

  modport slave (
    output instruction,
    input  blockRamReadEnable, blockRamWriteEnable, registerFileWriteEnable,
    input  integerTypeSelectionLine, reg2OrImmediateSelectionLine,
    input  pcOrRegisterSelectionLine, addressFromRegOrDecoderSelectionLine,
    input  writeBackToRegRamOrALUSelectionLine, pcOrAluOutputRamReadSelectionLine,
    input  decoderRamWriteAddress, registerWriteAddress,
    input  instructionRegisterLoad, pcIncrement, halted
`ifdef CPU_CONTROL_RETIRE_COUNT_EN
    , input retiredCount
`endif
  );
endinterface

// File: rtl/cpu_control_fsm.sv
// Multi-cycle Moore control unit for the 16-bit CPU datapath (fetch/decode/execute/memory).
// Optional retired-instruction counter enabled by defining CPU_CONTROL_RETIRE_COUNT_EN.
module cpu_control_fsm #(
  parameter logic [15:0] IO_BASE       = 16'hFF00,
  parameter int unsigned RESET_PC_HOLD = 0
) (
  input logic           clock,
  input logic           reset,
  cpu_control_if.master ctrl
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FETCH      = 3'd1,
    S_FETCH_WAIT = 3'd2,
    S_DECODE     = 3'd3,
    S_EXEC       = 3'd4,
    S_MEM_WAIT   = 3'd5,
    S_HALT       = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    C_RTYPE = 3'd0,
    C_IMM_S = 3'd1,
    C_IMM_Z = 3'd2,
    C_LOAD  = 3'd3,
    C_STOR  = 3'd4,
    C_OUT   = 3'd5,
    C_HALT  = 3'd6,
    C_NOP   = 3'd7
  } class_e;

  localparam logic [3:0] HOLD_INIT = 4'(RESET_PC_HOLD);

  function automatic class_e classify(input logic [15:0] ins);
    class_e c;
    case (ins[15:12])
      4'h0:             c = C_RTYPE;
      4'h1, 4'h2, 4'h3: c = C_IMM_S;
      4'h4, 4'h5, 4'h6: c = C_IMM_Z;
      4'h7: begin
        if (ins[7:4] == 4'h0) begin
          c = C_LOAD;
        end else if (ins[7:4] == 4'h4) begin
          c = C_STOR;
        end else begin
          c = C_NOP;
        end
      end
      4'h8:    c = C_OUT;
      4'hF:    c = C_HALT;
      default: c = C_NOP;
    endcase
    return c;
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  hold_q, hold_d;
  logic [15:0] instr_q;
  logic [15:0] cur_instr_s;
  class_e      cur_class_s;

  logic        rd_en_q, rd_en_d;
  logic        wr_en_q, wr_en_d;
  logic        rf_we_q, rf_we_d;
  logic [1:0]  int_sel_q, int_sel_d;
  logic        imm_sel_q, imm_sel_d;
  logic        a_sel_q, a_sel_d;
  logic        addr_sel_q, addr_sel_d;
  logic        wb_sel_q, wb_sel_d;
  logic        rd_addr_sel_q, rd_addr_sel_d;
  logic [15:0] io_addr_q, io_addr_d;
  logic [3:0]  rf_waddr_q, rf_waddr_d;
  logic        ir_load_q, ir_load_d;
  logic        pc_inc_q, pc_inc_d;
  logic        halted_q, halted_d;

  // The IR is only trusted during DECODE; later phases work from the latched copy.
  assign cur_instr_s = (state_q == S_DECODE) ? ctrl.instruction : instr_q;
  assign cur_class_s = classify(cur_instr_s);

  // Next-state and IDLE hold-counter logic.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        if (hold_q == 4'd0) begin
          state_d = S_FETCH;
        end else begin
          hold_d = hold_q - 4'd1;
        end
      end
      S_FETCH:      state_d = S_FETCH_WAIT;
      S_FETCH_WAIT: state_d = S_DECODE;
      S_DECODE: begin
        if (cur_class_s == C_HALT) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cur_class_s == C_LOAD) begin
          state_d = S_MEM_WAIT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM_WAIT: state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_IDLE;
    endcase
  end

  // Output decode of the upcoming state, so every output leaves a flop.
  always_comb begin
    rd_en_d       = 1'b0;
    wr_en_d       = 1'b0;
    rf_we_d       = 1'b0;
    int_sel_d     = 2'b00;
    imm_sel_d     = 1'b0;
    a_sel_d       = 1'b0;
    addr_sel_d    = 1'b0;
    wb_sel_d      = 1'b0;
    rd_addr_sel_d = 1'b0;
    io_addr_d     = 16'h0000;
    rf_waddr_d    = 4'h0;
    ir_load_d     = 1'b0;
    pc_inc_d      = 1'b0;
    halted_d      = 1'b0;
    case (state_d)
      S_FETCH: begin
        rd_en_d       = 1'b1;
        rd_addr_sel_d = 1'b1;
      end
      S_FETCH_WAIT: begin
        ir_load_d = 1'b1;
        pc_inc_d  = 1'b1;
      end
      S_EXEC: begin
        case (cur_class_s)
          C_RTYPE, C_IMM_S, C_IMM_Z: begin
            a_sel_d    = 1'b1;
            wb_sel_d   = 1'b1;
            rf_we_d    = 1'b1;
            rf_waddr_d = cur_instr_s[11:8];
            if (cur_class_s == C_IMM_S) begin
              imm_sel_d = 1'b1;
              int_sel_d = 2'b01;
            end else if (cur_class_s == C_IMM_Z) begin
              imm_sel_d = 1'b1;
              int_sel_d = 2'b10;
            end else begin
              imm_sel_d = 1'b0;
              int_sel_d = 2'b00;
            end
          end
          C_LOAD: begin
            a_sel_d = 1'b1;
            rd_en_d = 1'b1;
          end
          C_STOR: begin
            a_sel_d = 1'b1;
            wr_en_d = 1'b1;
          end
          C_OUT: begin
            a_sel_d    = 1'b1;
            addr_sel_d = 1'b1;
            wr_en_d    = 1'b1;
            io_addr_d  = IO_BASE + {8'h00, cur_instr_s[7:0]};
          end
          default: begin
            a_sel_d = 1'b0;
          end
        endcase
      end
      S_MEM_WAIT: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = cur_instr_s[3:0];
      end
      S_HALT: halted_d = 1'b1;
      default: begin
        halted_d = 1'b0;
      end
    endcase
  end

  // State, hold counter and latched instruction.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      hold_q  <= HOLD_INIT;
      instr_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      if (state_q == S_DECODE) begin
        instr_q <= ctrl.instruction;
      end else begin
        instr_q <= instr_q;
      end
    end
  end

  // Registered control outputs; reset clears every strobe asynchronously.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_en_q       <= 1'b0;
      wr_en_q       <= 1'b0;
      rf_we_q       <= 1'b0;
      int_sel_q     <= 2'b00;
      imm_sel_q     <= 1'b0;
      a_sel_q       <= 1'b0;
      addr_sel_q    <= 1'b0;
      wb_sel_q      <= 1'b0;
      rd_addr_sel_q <= 1'b0;
      io_addr_q     <= 16'h0000;
      rf_waddr_q    <= 4'h0;
      ir_load_q     <= 1'b0;
      pc_inc_q      <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      rd_en_q       <= rd_en_d;
      wr_en_q       <= wr_en_d;
      rf_we_q       <= rf_we_d;
      int_sel_q     <= int_sel_d;
      imm_sel_q     <= imm_sel_d;
      a_sel_q       <= a_sel_d;
      addr_sel_q    <= addr_sel_d;
      wb_sel_q      <= wb_sel_d;
      rd_addr_sel_q <= rd_addr_sel_d;
      io_addr_q     <= io_addr_d;
      rf_waddr_q    <= rf_waddr_d;
      ir_load_q     <= ir_load_d;
      pc_inc_q      <= pc_inc_d;
      halted_q      <= halted_d;
    end
  end

  assign ctrl.blockRamReadEnable                  = rd_en_q;
  assign ctrl.blockRamWriteEnable                 = wr_en_q;
  assign ctrl.registerFileWriteEnable             = rf_we_q;
  assign ctrl.integerTypeSelectionLine            = int_sel_q;
  assign ctrl.reg2OrImmediateSelectionLine        = imm_sel_q;
  assign ctrl.pcOrRegisterSelectionLine           = a_sel_q;
  assign ctrl.addressFromRegOrDecoderSelectionLine = addr_sel_q;
  assign ctrl.writeBackToRegRamOrALUSelectionLine = wb_sel_q;
  assign ctrl.pcOrAluOutputRamReadSelectionLine   = rd_addr_sel_q;
  assign ctrl.decoderRamWriteAddress              = io_addr_q;
  assign ctrl.registerWriteAddress                = rf_waddr_q;
  assign ctrl.instructionRegisterLoad             = ir_load_q;
  assign ctrl.pcIncrement                         = pc_inc_q;
  assign ctrl.halted                              = halted_q;

`ifdef CPU_CONTROL_RETIRE_COUNT_EN
  logic [31:0] retired_q;

  // Counts an instruction on its last cycle: EXEC, or MEM_WAIT for LOAD.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      retired_q <= 32'h0000_0000;
    end else if ((state_q == S_EXEC && state_d == S_FETCH) || state_q == S_MEM_WAIT) begin
      retired_q <= retired_q + 32'h0000_0001;
    end else begin
      retired_q <= retired_q;
    end
  end

  assign ctrl.retiredCount = retired_q;
`endif

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Randomized self-checking bench for cpu_control_fsm against a per-instruction cycle model.
module tb_cpu_control_fsm;
  localparam logic [15:0] IO_BASE = 16'hFF00;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
`ifdef CPU_CONTROL_RETIRE_COUNT_EN
  logic [31:0] ret_model = 32'd0;
`endif

  cpu_control_if ctrl_if();

  cpu_control_fsm #(.IO_BASE(IO_BASE), .RESET_PC_HOLD(0)) dut (
    .clock(clock),
    .reset(reset),
    .ctrl (ctrl_if)
  );

  always #5 clock = ~clock;

  // {rd, wr, rfwe, int[1:0], imm, asel, addrsel, wb, pcrd, io_addr[15:0], waddr[3:0], irld, pcinc, halted}
  function automatic logic [32:0] mk(input logic rd, input logic wr, input logic we,
                                     input logic [1:0] it, input logic r2, input logic asel,
                                     input logic dsel, input logic wb, input logic pcrd,
                                     input logic [15:0] dec, input logic [3:0] wa,
                                     input logic ir, input logic inc, input logic hlt);
    return {rd, wr, we, it, r2, asel, dsel, wb, pcrd, dec, wa, ir, inc, hlt};
  endfunction

  function automatic logic [32:0] observed();
    return {ctrl_if.blockRamReadEnable, ctrl_if.blockRamWriteEnable,
            ctrl_if.registerFileWriteEnable, ctrl_if.integerTypeSelectionLine,
            ctrl_if.reg2OrImmediateSelectionLine, ctrl_if.pcOrRegisterSelectionLine,
            ctrl_if.addressFromRegOrDecoderSelectionLine,
            ctrl_if.writeBackToRegRamOrALUSelectionLine,
            ctrl_if.pcOrAluOutputRamReadSelectionLine, ctrl_if.decoderRamWriteAddress,
            ctrl_if.registerWriteAddress, ctrl_if.instructionRegisterLoad,
            ctrl_if.pcIncrement, ctrl_if.halted};
  endfunction

  // Expected outputs during the execute cycle of one instruction.
  function automatic logic [32:0] exp_exec(input logic [15:0] ins);
    logic [3:0] op;
    logic [3:0] ext;
    logic [3:0] ra;
    op  = ins[15:12];
    ext = ins[7:4];
    ra  = ins[11:8];
    if (op == 4'h0) return mk(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, ra, 1'b0, 1'b0, 1'b0);
    if (op >= 4'h1 && op <= 4'h3) return mk(1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, ra, 1'b0, 1'b0, 1'b0);
    if (op >= 4'h4 && op <= 4'h6) return mk(1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, ra, 1'b0, 1'b0, 1'b0);
    if (op == 4'h7 && ext == 4'h0) return mk(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0);
    if (op == 4'h7 && ext == 4'h4) return mk(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0);
    if (op == 4'h8) return mk(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, IO_BASE + {8'h00, ins[7:0]}, 4'h0, 1'b0, 1'b0, 1'b0);
    return 33'd0;
  endfunction

  task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_async", observed(), 33'd0);
`ifdef CPU_CONTROL_RETIRE_COUNT_EN
    chk("rst_retired", {1'b0, ctrl_if.retiredCount}, 33'd0);
    ret_model = 32'd0;
`endif
    tick();
    chk("rst_held", observed(), 33'd0);
    reset = 1'b1;
  endtask

  // One instruction from FETCH to its last cycle; the IR carries noise outside DECODE.
  task automatic run_instr(input logic [15:0] ins, input bit abort_in_exec);
    ctrl_if.instruction = 16'($urandom);
    tick();
    chk("fetch", observed(), mk(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0));
`ifdef CPU_CONTROL_RETIRE_COUNT_EN
    chk("retired", {1'b0, ctrl_if.retiredCount}, {1'b0, ret_model});
`endif
    tick();
    chk("fetch_wait", observed(), mk(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, 1'b1, 1'b1, 1'b0));
    ctrl_if.instruction = ins;
    tick();
    chk("decode", observed(), 33'd0);
    tick();
    if (ins[15:12] == 4'hF) begin
      for (int i = 0; i < 20; i++) begin
        chk("halt", observed(), mk(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b1));
        ctrl_if.instruction = 16'($urandom);
        tick();
      end
      return;
    end
    chk("exec", observed(), exp_exec(ins));
    ctrl_if.instruction = 16'($urandom);
    if (abort_in_exec) begin
      do_reset();
      return;
    end
    if (ins[15:12] == 4'h7 && ins[7:4] == 4'h0) begin
      tick();
      chk("mem_wait", observed(), mk(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, ins[3:0], 1'b0, 1'b0, 1'b0));
    end
`ifdef CPU_CONTROL_RETIRE_COUNT_EN
    ret_model = ret_model + 32'd1;
`endif
  endtask

  initial begin
    logic [15:0] r;
    ctrl_if.instruction = 16'h0000;
    #3;
    chk("reset", observed(), 33'd0);
    @(negedge clock);
    reset = 1'b1;

    run_instr(16'h0000, 1'b0);
    run_instr(16'h1305, 1'b0);
    run_instr(16'h7203, 1'b0);
    run_instr(16'h8512, 1'b0);
    run_instr(16'h85FF, 1'b0);
    run_instr(16'h7A4C, 1'b0);
    run_instr(16'h4B7C, 1'b0);
    run_instr(16'h9123, 1'b0);
    run_instr(16'h7215, 1'b0);

    for (int n = 0; n < 200; n++) begin
      r = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        r[15:12] = 4'h7;
        r[7:4]   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'h4;
      end
      if (r[15:12] == 4'hF) r[15:12] = 4'hC;
      run_instr(r, 1'b0);
    end

    run_instr(16'h7345, 1'b1);
    run_instr(16'h0000, 1'b0);
    run_instr(16'h7203, 1'b0);
    run_instr(16'hF000, 1'b0);
    do_reset();
    run_instr(16'h1305, 1'b0);
    run_instr(16'h8512, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
